posit_accum_feeder: RTL and testbench



---
 rtl/posit_accum_feeder.sv | 223 ++++++++++++++++++++++
 tb/tb_posit_accum_feeder.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/posit_accum_feeder.sv
// Sequencer feeding one posit term at a time into the posit accumulator and returning each frame's sum.
// Optional WAIT watchdog is compiled in by defining POSIT_FEEDER_WATCHDOG_EN.
module posit_accum_feeder #(
  parameter int NBITS   = 32,
  parameter int ACC_LAT = 8,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [NBITS-1:0] s_data,
  input  logic             s_last,
  output logic [NBITS-1:0] acc_in,
  output logic             acc_start,
  output logic             acc_clear,
  input  logic [NBITS-1:0] acc_result,
  input  logic             acc_inf,
  input  logic             acc_done,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [NBITS-1:0] m_data,
  output logic             m_inf,
  output logic             m_err,
  output logic [15:0]      m_count
);

  localparam logic [NBITS-1:0] NAR  = {1'b1, {(NBITS-1){1'b0}}};
  localparam logic [NBITS-1:0] ZERO = {NBITS{1'b0}};

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_OUT   = 3'd4
  } state_t;

  state_t           state_r, state_s;
  logic             first_r, first_s;
  logic [NBITS-1:0] held_data_r, held_data_s;
  logic             held_last_r, held_last_s;
  logic [NBITS-1:0] sum_r, sum_s;
  logic [15:0]      cnt_r, cnt_s, cnt_inc_s;
  logic             nar_r, nar_s;
  logic             err_r, err_s;
  logic             hs_s;
  logic             timeout_s;

  logic             s_ready_s, acc_start_s, acc_clear_s, m_valid_s, m_inf_s, m_err_s;
  logic [NBITS-1:0] acc_in_s, m_data_s;
  logic [15:0]      m_count_s;

  // A TIMEOUT at or below ACC_LAT would flag every healthy term as hung.
  if (TIMEOUT <= ACC_LAT) begin : g_timeout_below_latency
  end

`ifdef POSIT_FEEDER_WATCHDOG_EN
  localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);
  logic [15:0] wd_cnt_r;

  // Cycles spent in WAIT for the term currently in flight
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wd_cnt_r <= 16'd0;
    end else if (state_r == ST_WAIT) begin
      wd_cnt_r <= wd_cnt_r + 16'd1;
    end else begin
      wd_cnt_r <= 16'd0;
    end
  end

  assign timeout_s = (state_r == ST_WAIT) && (wd_cnt_r == WD_LAST);

  // Sticky per-frame watchdog error flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_r <= 1'b0;
    end else begin
      err_r <= err_s;
    end
  end
`else
  assign timeout_s = 1'b0;
  assign err_r     = 1'b0;
`endif

  // Next-state logic and next values of every registered output
  always_comb begin
    state_s     = state_r;
    first_s     = first_r;
    held_data_s = held_data_r;
    held_last_s = held_last_r;
    sum_s       = sum_r;
    cnt_s       = cnt_r;
    nar_s       = nar_r;
    err_s       = err_r;
    hs_s        = s_valid & s_ready;
    cnt_inc_s   = (cnt_r == 16'hFFFF) ? cnt_r : cnt_r + 16'd1;

    case (state_r)
      ST_IDLE: begin
        if (hs_s) begin
          cnt_s = cnt_inc_s;
          if (s_data == NAR) begin
            nar_s   = 1'b1;
            state_s = s_last ? ST_OUT : ST_DRAIN;
          end else if ((s_data == ZERO) && !first_r) begin
            state_s = s_last ? ST_OUT : ST_IDLE;
          end else begin
            // A leading zero is still issued so that it clears the accumulator.
            held_data_s = s_data;
            held_last_s = s_last;
            state_s     = ST_ISSUE;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        first_s = 1'b0;
        state_s = ST_WAIT;
      end
      ST_WAIT: begin
        if (acc_done) begin
          sum_s = acc_result;
          nar_s = nar_r | acc_inf;
          if (held_last_r) begin
            state_s = ST_OUT;
          end else if (nar_r | acc_inf) begin
            state_s = ST_DRAIN;
          end else begin
            state_s = ST_IDLE;
          end
        end else if (timeout_s) begin
          err_s   = 1'b1;
          state_s = held_last_r ? ST_OUT : ST_DRAIN;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_DRAIN: begin
        if (hs_s) begin
          cnt_s   = cnt_inc_s;
          state_s = s_last ? ST_OUT : ST_DRAIN;
        end else begin
          state_s = ST_DRAIN;
        end
      end
      ST_OUT: begin
        if (m_ready) begin
          first_s = 1'b1;
          cnt_s   = 16'd0;
          nar_s   = 1'b0;
          sum_s   = ZERO;
          err_s   = 1'b0;
          state_s = ST_IDLE;
        end else begin
          state_s = ST_OUT;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase

    s_ready_s   = (state_s == ST_IDLE) || (state_s == ST_DRAIN);
    acc_start_s = (state_s == ST_ISSUE);
    acc_clear_s = (state_s == ST_ISSUE) && first_s;
    acc_in_s    = acc_start_s ? held_data_s : ZERO;
    m_valid_s   = (state_s == ST_OUT);
    m_inf_s     = m_valid_s && (nar_s || err_s);
    m_err_s     = m_valid_s && err_s;
    m_count_s   = m_valid_s ? cnt_s : 16'd0;
    if (!m_valid_s) begin
      m_data_s = ZERO;
    end else if (nar_s || err_s) begin
      m_data_s = NAR;
    end else begin
      m_data_s = sum_s;
    end
  end

  // State, frame registers and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      first_r     <= 1'b1;
      held_data_r <= ZERO;
      held_last_r <= 1'b0;
      sum_r       <= ZERO;
      cnt_r       <= 16'd0;
      nar_r       <= 1'b0;
      s_ready     <= 1'b0;
      acc_start   <= 1'b0;
      acc_clear   <= 1'b0;
      acc_in      <= ZERO;
      m_valid     <= 1'b0;
      m_data      <= ZERO;
      m_inf       <= 1'b0;
      m_err       <= 1'b0;
      m_count     <= 16'd0;
    end else begin
      state_r     <= state_s;
      first_r     <= first_s;
      held_data_r <= held_data_s;
      held_last_r <= held_last_s;
      sum_r       <= sum_s;
      cnt_r       <= cnt_s;
      nar_r       <= nar_s;
      s_ready     <= s_ready_s;
      acc_start   <= acc_start_s;
      acc_clear   <= acc_clear_s;
      acc_in      <= acc_in_s;
      m_valid     <= m_valid_s;
      m_data      <= m_data_s;
      m_inf       <= m_inf_s;
      m_err       <= m_err_s;
      m_count     <= m_count_s;
    end
  end

endmodule

// File: tb/tb_posit_accum_feeder.sv
// Bench for posit_accum_feeder: behavioural accumulator, directed frames and randomized frames vs a reference model.
module tb_posit_accum_feeder;

  localparam int ACC_LAT = 8;
  localparam int TIMEOUT = 64;
  localparam logic [31:0] NAR = 32'h8000_0000;

  logic clk = 1'b0, rst_n = 1'b0;
  logic s_valid = 1'b0, s_last = 1'b0, s_ready;
  logic [31:0] s_data = 32'd0;
  logic [31:0] acc_in, acc_result = 32'd0;
  logic acc_start, acc_clear, acc_inf = 1'b0, acc_done = 1'b0;
  logic m_valid, m_ready = 1'b0, m_inf, m_err;
  logic [31:0] m_data;
  logic [15:0] m_count;

  posit_accum_feeder #(.NBITS(32), .ACC_LAT(ACC_LAT), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .acc_in(acc_in), .acc_start(acc_start), .acc_clear(acc_clear), .acc_result(acc_result),
    .acc_inf(acc_inf), .acc_done(acc_done), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_inf(m_inf), .m_err(m_err), .m_count(m_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0, n_fail = 0;

  logic [31:0] frame[$];
  logic [32:0] resp_list[8];
  logic [32:0] resp_q[$];
  logic [31:0] iss_term[$];
  logic        iss_clear[$];
  int          start_cycles[$], done_cycles[$], hs_cycles[$];
  logic [31:0] exp_term[$];
  logic        exp_clear[$];
  logic [31:0] exp_data;
  logic        exp_inf;
  int          exp_count;
  logic [31:0] got_data;
  logic        got_inf, got_err;
  logic [15:0] got_count;
  int          mv_cyc;
  logic [31:0] hold_data[$];
  logic [1:0]  hold_flags[$];
  logic [1:0]  after_flags;
  bit          acc_mute = 1'b0;

  // Behavioural accumulator: answers each start ACC_LAT cycles later from the response queue.
  int cd = 0;
  logic [32:0] cur_resp = 33'd0;
  always @(negedge clk) begin
    acc_done = 1'b0;
    if (cd > 0) begin
      cd--;
      if (cd == 0) begin
        acc_done = 1'b1;
        acc_result = cur_resp[31:0];
        acc_inf = cur_resp[32];
        done_cycles.push_back(cyc);
      end
    end
    if (acc_start === 1'b1) begin
      n_checks++;
      if (cd != 0) begin
        n_fail++;
        $display("FAIL overlap: acc_start with %0d cycles still in flight, required 0", cd);
      end
      iss_term.push_back(acc_in);
      iss_clear.push_back(acc_clear);
      start_cycles.push_back(cyc);
      if (resp_q.size() > 0) cur_resp = resp_q.pop_front();
      else cur_resp = {1'b0, $urandom};
      if (!acc_mute) cd = ACC_LAT;
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running, required completion");
    $fatal(1, "global timeout");
  end

  task automatic clear_logs();
    iss_term.delete(); iss_clear.delete(); start_cycles.delete();
    done_cycles.delete(); hs_cycles.delete(); resp_q.delete();
  endtask

  task automatic send_frame(input int max_gap, input bit mark_last);
    for (int i = 0; i < frame.size(); i++) begin
      int gap, waited;
      bit got;
      gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
      s_valid = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
      s_valid = 1'b1; s_data = frame[i]; s_last = mark_last && (i == frame.size() - 1);
      waited = 0; got = 1'b0;
      while (!got && waited < 300) begin
        @(negedge clk);
        if (s_ready === 1'b1) begin got = 1'b1; hs_cycles.push_back(cyc); end
        @(posedge clk); #1;
        waited++;
      end
      if (!got) begin
        n_checks++; n_fail++;
        $display("FAIL send_timeout: term %0d not accepted after %0d cycles, required acceptance", i, waited);
      end
    end
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic receive(input int hold);
    int waited = 0;
    bit got = 1'b0;
    while (!got && waited < 600) begin
      @(negedge clk);
      if (m_valid === 1'b1) got = 1'b1;
      else waited++;
    end
    if (!got) begin
      n_checks++; n_fail++;
      $display("FAIL recv_timeout: m_valid low for %0d cycles, required 1", waited);
      @(posedge clk); #1;
    end else begin
      mv_cyc = cyc; got_data = m_data; got_inf = m_inf; got_err = m_err; got_count = m_count;
      hold_data.delete(); hold_flags.delete();
      repeat (hold) begin
        @(negedge clk);
        hold_data.push_back(m_data);
        hold_flags.push_back({m_valid, s_ready});
      end
      @(posedge clk); #1; m_ready = 1'b1;
      @(posedge clk); #1; m_ready = 1'b0;
      @(negedge clk); after_flags = {m_valid, s_ready};
      @(posedge clk); #1;
    end
  endtask

  // Reference: issue decisions and final sum straight from the frame rules.
  task automatic run_model();
    bit first = 1'b1, nar = 1'b0, drain = 1'b0;
    logic [31:0] sum = 32'd0;
    int k = 0;
    exp_term.delete(); exp_clear.delete(); exp_count = 0;
    foreach (frame[i]) begin
      exp_count++;
      if (!drain) begin
        if (frame[i] == NAR) begin
          nar = 1'b1; drain = 1'b1;
        end else if (frame[i] != 32'd0 || first) begin
          exp_term.push_back(frame[i]); exp_clear.push_back(first); first = 1'b0;
          sum = resp_list[k][31:0];
          if (resp_list[k][32]) begin nar = 1'b1; drain = 1'b1; end
          k++;
        end
      end
    end
    exp_data = nar ? NAR : sum;
    exp_inf = nar;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) begin @(posedge clk); end
    #1;
    n_checks++;
    if (s_ready !== 1'b0) begin n_fail++; $display("FAIL reset_s_ready: got %b, required 0", s_ready); end
    n_checks++;
    if ({acc_start, acc_clear, m_valid, m_inf, m_err} !== 5'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b, required 00000", {acc_start, acc_clear, m_valid, m_inf, m_err});
    end
    n_checks++;
    if ({acc_in, m_data, m_count} !== 80'd0) begin
      n_fail++; $display("FAIL reset_data: acc_in=%h m_data=%h m_count=%0d, required all 0", acc_in, m_data, m_count);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (s_ready !== 1'b1) begin n_fail++; $display("FAIL release_s_ready: got %b, required 1", s_ready); end
  endtask

  task automatic test_two_term();
    clear_logs();
    resp_q.push_back({1'b0, 32'h4000_0000}); resp_q.push_back({1'b0, 32'h4800_0000});
    frame = '{32'h4000_0000, 32'h4000_0000};
    send_frame(0, 1'b1);
    receive(0);
    n_checks++;
    if (iss_term.size() != 2) begin
      n_fail++; $display("FAIL two_issue_count: got %0d, required 2", iss_term.size());
    end else begin
      n_checks++;
      if ({iss_clear[0], iss_clear[1]} !== 2'b10) begin
        n_fail++; $display("FAIL two_clear: got %b%b, required 10", iss_clear[0], iss_clear[1]);
      end
      n_checks++;
      if (hs_cycles.size() != 2 || done_cycles.size() < 1 || hs_cycles[1] != done_cycles[0] + 1) begin
        n_fail++; $display("FAIL two_ready_after_done: second accept not at done+1, required done+1");
      end
    end
    n_checks++;
    if ({got_data, got_inf, got_err, got_count} !== {32'h4800_0000, 1'b0, 1'b0, 16'd2}) begin
      n_fail++; $display("FAIL two_result: data=%h inf=%b err=%b cnt=%0d, required 48000000 0 0 2", got_data, got_inf, got_err, got_count);
    end
  endtask

  task automatic test_zero_skip();
    clear_logs();
    resp_q.push_back({1'b0, 32'h4000_0000});
    frame = '{32'h4000_0000, 32'h0000_0000, 32'h0000_0000};
    send_frame(0, 1'b1);
    receive(1);
    n_checks++;
    if (iss_term.size() != 1) begin n_fail++; $display("FAIL zero_issue_count: got %0d, required 1", iss_term.size()); end
    n_checks++;
    if (hs_cycles.size() != 3 || hs_cycles[2] != hs_cycles[1] + 1 || mv_cyc != hs_cycles[2] + 1) begin
      n_fail++; $display("FAIL zero_no_gap: skipped terms not back to back, required consecutive accepts");
    end
    n_checks++;
    if ({got_data, got_inf, got_count} !== {32'h4000_0000, 1'b0, 16'd3}) begin
      n_fail++; $display("FAIL zero_result: data=%h inf=%b cnt=%0d, required 40000000 0 3", got_data, got_inf, got_count);
    end
  endtask

  task automatic test_nar_drain();
    clear_logs();
    resp_q.push_back({1'b0, 32'h4000_0000});
    frame = '{32'h4000_0000, NAR, 32'h4000_0000, 32'h4000_0000};
    send_frame(1, 1'b1);
    receive(0);
    n_checks++;
    if (iss_term.size() != 1) begin n_fail++; $display("FAIL nar_issue_count: got %0d, required 1", iss_term.size()); end
    n_checks++;
    if ({got_data, got_inf, got_count} !== {NAR, 1'b1, 16'd4}) begin
      n_fail++; $display("FAIL nar_result: data=%h inf=%b cnt=%0d, required 80000000 1 4", got_data, got_inf, got_count);
    end
  endtask

  task automatic test_latency_hold();
    clear_logs();
    resp_q.push_back({1'b0, 32'h3800_0000});
    frame = '{32'h3000_0000};
    send_frame(0, 1'b1);
    receive(5);
    n_checks++;
    if (hs_cycles.size() != 1 || start_cycles.size() != 1 || done_cycles.size() != 1) begin
      n_fail++; $display("FAIL lat_events: accepts=%0d starts=%0d dones=%0d, required 1 1 1", hs_cycles.size(), start_cycles.size(), done_cycles.size());
    end else begin
      n_checks++;
      if (start_cycles[0] != hs_cycles[0] + 1) begin
        n_fail++; $display("FAIL lat_start: start at %0d, required %0d", start_cycles[0], hs_cycles[0] + 1);
      end
      n_checks++;
      if (mv_cyc != done_cycles[0] + 1) begin
        n_fail++; $display("FAIL lat_valid: m_valid at %0d, required %0d", mv_cyc, done_cycles[0] + 1);
      end
    end
    foreach (hold_data[i]) begin
      n_checks++;
      if ({hold_data[i], hold_flags[i]} !== {32'h3800_0000, 2'b10}) begin
        n_fail++; $display("FAIL hold_stable: cycle %0d data=%h valid/ready=%b, required 38000000 10", i, hold_data[i], hold_flags[i]);
      end
    end
    n_checks++;
    if (after_flags !== 2'b01) begin n_fail++; $display("FAIL after_handshake: valid/ready=%b, required 01", after_flags); end
  endtask

  task automatic test_reset_mid_frame();
    int stale_bad = 0;
    clear_logs();
    frame = '{32'h4000_0000};
    send_frame(0, 1'b0);
    repeat (3) begin @(posedge clk); end
    #1; rst_n = 1'b0;
    repeat (2) begin @(posedge clk); end
    #1;
    n_checks++;
    if ({s_ready, m_valid, acc_start} !== 3'b000) begin
      n_fail++; $display("FAIL midreset_outputs: ready/valid/start=%b, required 000", {s_ready, m_valid, acc_start});
    end
    rst_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (m_valid !== 1'b0 || acc_start !== 1'b0) stale_bad++;
    end
    @(posedge clk); #1;
    n_checks++;
    if (stale_bad != 0) begin n_fail++; $display("FAIL stale_done: %0d cycles with output activity, required 0", stale_bad); end
    clear_logs();
    resp_q.push_back({1'b0, 32'h2000_0000});
    frame = '{32'h5000_0000};
    send_frame(0, 1'b1);
    receive(0);
    n_checks++;
    if (iss_clear.size() != 1 || iss_clear[0] !== 1'b1) begin
      n_fail++; $display("FAIL midreset_clear: %0d issues, required one with acc_clear=1", iss_clear.size());
    end
    n_checks++;
    if ({got_data, got_count} !== {32'h2000_0000, 16'd1}) begin
      n_fail++; $display("FAIL midreset_result: data=%h cnt=%0d, required 20000000 1", got_data, got_count);
    end
  endtask

  task automatic test_random();
    for (int f = 0; f < 25; f++) begin
      int len;
      clear_logs();
      len = int'($urandom_range(1, 6));
      frame.delete();
      for (int i = 0; i < len; i++) begin
        int r;
        logic [31:0] v;
        r = int'($urandom_range(0, 9));
        v = $urandom;
        if (v == 32'd0 || v == NAR) v = 32'h4000_1234;
        if (r < 4) v = 32'd0;
        else if (r == 4) v = NAR;
        frame.push_back(v);
      end
      for (int k = 0; k < 8; k++) begin
        resp_list[k] = {($urandom_range(0, 9) == 0), $urandom};
        resp_q.push_back(resp_list[k]);
      end
      run_model();
      send_frame(2, 1'b1);
      receive(int'($urandom_range(0, 3)));
      n_checks++;
      if (iss_term.size() != exp_term.size()) begin
        n_fail++; $display("FAIL rnd_issue_count: frame %0d got %0d, required %0d", f, iss_term.size(), exp_term.size());
      end else begin
        foreach (exp_term[k]) begin
          n_checks++;
          if ({iss_term[k], iss_clear[k]} !== {exp_term[k], exp_clear[k]}) begin
            n_fail++; $display("FAIL rnd_issue: frame %0d issue %0d got %h/%b, required %h/%b", f, k, iss_term[k], iss_clear[k], exp_term[k], exp_clear[k]);
          end
        end
      end
      n_checks++;
      if ({got_data, got_inf, got_err, got_count} !== {exp_data, exp_inf, 1'b0, 16'(exp_count)}) begin
        n_fail++; $display("FAIL rnd_result: frame %0d data=%h inf=%b err=%b cnt=%0d, required %h %b 0 %0d", f, got_data, got_inf, got_err, got_count, exp_data, exp_inf, exp_count);
      end
    end
  endtask

`ifdef POSIT_FEEDER_WATCHDOG_EN
  task automatic test_watchdog();
    clear_logs();
    acc_mute = 1'b1;
    frame = '{32'h4000_0000, 32'h3000_0000, 32'h4000_0000};
    send_frame(0, 1'b1);
    receive(0);
    acc_mute = 1'b0;
    n_checks++;
    if (iss_term.size() != 1) begin n_fail++; $display("FAIL wd_issue_count: got %0d, required 1", iss_term.size()); end
    n_checks++;
    if ({got_data, got_inf, got_err, got_count} !== {NAR, 1'b1, 1'b1, 16'd3}) begin
      n_fail++; $display("FAIL wd_result: data=%h inf=%b err=%b cnt=%0d, required 80000000 1 1 3", got_data, got_inf, got_err, got_count);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_two_term();
    test_zero_skip();
    test_nar_drain();
    test_latency_hold();
    test_reset_mid_frame();
    test_random();
`ifdef POSIT_FEEDER_WATCHDOG_EN
    test_watchdog();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
